io_port: RTL

//  Programmed-I/O front end that sits between the cpu keyboard/display ports and the

---
 rtl/io_port.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/io_port.sv
// Programmed-I/O front end: keyboard FIFO with FGI flag, display pacing timer with FGO flag,
// and a combined interrupt request.
module io_port #(
    parameter int DW          = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int DISP_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_kbd_strobe,
    input  logic [DW-1:0] i_kbd_data,
    input  logic          i_inp_rd,
    output logic [DW-1:0] o_inp_data,
    output logic          o_fgi,
    input  logic          i_out_wr,
    input  logic [DW-1:0] i_out_data,
    output logic          o_fgo,
    output logic [DW-1:0] o_display,
    output logic          o_disp_valid,
    input  logic          i_en_inp,
    input  logic          i_en_out,
    output logic          o_intr,
    output logic          o_kbd_ovr,
    output logic          o_out_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    typedef enum logic {
        READY = 1'b0,
        BUSY  = 1'b1
    } disp_state_t;

    // keyboard FIFO state
    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_strobe_q;
    logic          r_kbd_ovr;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic w_wr_en;

    // display state
    disp_state_t   r_state;
    disp_state_t   w_state_nxt;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;
    logic [DW-1:0] r_display;
    logic          r_disp_valid;
    logic          r_out_err;
    logic          w_disp_ld;
    logic          w_err_set;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_push  = i_kbd_strobe & ~r_strobe_q;
    assign w_pop   = i_inp_rd & ~w_empty;
    // A push into a full FIFO survives only when a pop frees the head slot in the same cycle.
    assign w_wr_en = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_strobe_q <= 1'b0;
            r_kbd_ovr  <= 1'b0;
        end else begin
            r_strobe_q <= i_kbd_strobe;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_wr_en) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_kbd_ovr <= 1'b1;
            end
        end
    end

    // Storage carries data only, so it needs no reset; validity comes from r_count.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= i_kbd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= READY;
            r_cnt        <= '0;
            r_display    <= '0;
            r_disp_valid <= 1'b0;
            r_out_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_disp_valid <= w_disp_ld;
            if (w_disp_ld) begin
                r_display <= i_out_data;
            end
            if (w_err_set) begin
                r_out_err <= 1'b1;
            end
        end
    end

    // Loading DISP_CYCLES-1 keeps FGO low for exactly DISP_CYCLES cycles after the write edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_disp_ld   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            READY: begin
                if (i_out_wr) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = TW'(DISP_CYCLES - 1);
                    w_disp_ld   = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = READY;
                end else begin
                    w_cnt_nxt = r_cnt - TW'(1);
                end
                if (i_out_wr) begin
                    w_err_set = 1'b1;
                end
            end
            default: w_state_nxt = READY;
        endcase
    end

    assign o_inp_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_fgi        = ~w_empty;
    assign o_fgo        = (r_state == READY);
    assign o_display    = r_display;
    assign o_disp_valid = r_disp_valid;
    assign o_kbd_ovr    = r_kbd_ovr;
    assign o_out_err    = r_out_err;
    assign o_intr       = (i_en_inp & o_fgi) | (i_en_out & o_fgo);

endmodule
